// File: rtl/nb_pkg.sv
// Shared widths, FSM encoding and product sign-extension helper for the
// Naive Bayes dot-product sequencer.
package nb_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 36;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  // Sign-extension constants for the product before it enters the accumulator.
  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned EXT_W  = AW - PROD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [AW-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{EXT_W{p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/nb_dot_ctrl_if.sv
// Job request, memory read port and result handshake of the dot-product sequencer.
interface nb_dot_ctrl_if;
  import nb_pkg::*;

  logic                     start;
  logic [CNT_W-1:0]         len;
  logic [ADDR_W-1:0]        x_base;
  logic [ADDR_W-1:0]        w_base;
  logic                     busy;
  logic                     rd_en;
  logic [ADDR_W-1:0]        x_addr;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [DW-1:0]     x_data;
  logic signed [DW-1:0]     w_data;
  logic                     res_valid;
  logic                     res_ready;
  logic [AW-1:0]            result;
  logic                     ovf;

  // Job issuer plus memories.
  modport master (
    output start, len, x_base, w_base, x_data, w_data, res_ready,
    input  busy, rd_en, x_addr, w_addr, res_valid, result, ovf
  );

  // Sequencer.
  modport slave (
    input  start, len, x_base, w_base, x_data, w_data, res_ready,
    output busy, rd_en, x_addr, w_addr, res_valid, result, ovf
  );

endinterface

// File: rtl/nb_mac_acc.sv
// Signed multiply-accumulate with synchronous clear and sticky signed overflow.
module nb_mac_acc
  import nb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic [AW-1:0]        acc,
  output logic                 ovf
);

  logic signed [PROD_W-1:0] prod;
  logic [AW-1:0]            addend;
  logic [AW-1:0]            sum;
  logic                     ovf_now;

  assign prod    = PROD_W'(a) * PROD_W'(b);
  assign addend  = sext_prod(prod);
  assign sum     = acc + addend;
  // Like-signed addends producing an opposite-signed sum.
  assign ovf_now = (acc[AW-1] == addend[AW-1]) && (sum[AW-1] != acc[AW-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum;
      ovf <= ovf | ovf_now;
    end
  end

endmodule

// File: rtl/nb_dot_ctrl.sv
// Dot-product sequencer: streams len (x,w) pairs from two 1-cycle-latency
// memories into the MAC and returns the score on a valid/ready handshake.
module nb_dot_ctrl
  import nb_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  nb_dot_ctrl_if.slave bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  xa_q, xa_d;
  logic [ADDR_W-1:0]  wa_q, wa_d;
  logic               rd_q, rd_d;
  logic               busy_q, busy_d;
  logic               rv_q, rv_d;
  logic               vld_q;
  logic               accept;
  logic [AW-1:0]      acc;
  logic               acc_ovf;

  assign accept = (state_q == IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; a zero-length job passes through DRAIN so DONE lands one edge later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len == '0) ? DRAIN : FETCH;
      FETCH:   if (cnt_q == '0) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; cnt_q holds terms still to issue.
  always_comb begin
    cnt_d  = cnt_q;
    xa_d   = xa_q;
    wa_d   = wa_q;
    rd_d   = 1'b0;
    busy_d = 1'b0;
    rv_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        cnt_d = bus.len - CNT_W'(1);
        xa_d  = bus.x_base;
        wa_d  = bus.w_base;
        rd_d  = (bus.len != '0);
      end
      FETCH: if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
        xa_d  = xa_q + ADDR_W'(1);
        wa_d  = wa_q + ADDR_W'(1);
        rd_d  = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    rv_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      xa_q   <= '0;
      wa_q   <= '0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
      rv_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      xa_q   <= xa_d;
      wa_q   <= wa_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      rv_q   <= rv_d;
      vld_q  <= rd_q;
    end
  end

  nb_mac_acc u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (vld_q),
    .a       (bus.x_data),
    .b       (bus.w_data),
    .acc     (acc),
    .ovf     (acc_ovf)
  );

  assign bus.busy      = busy_q;
  assign bus.rd_en     = rd_q;
  assign bus.x_addr    = xa_q;
  assign bus.w_addr    = wa_q;
  assign bus.res_valid = rv_q;
  assign bus.result    = acc;
  assign bus.ovf       = acc_ovf;

endmodule

// File: tb/tb_nb_dot_ctrl.sv
// Directed bench for nb_dot_ctrl with behavioural 1-cycle-latency memories.
module tb_nb_dot_ctrl;
  import nb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  initial forever #5 clk = ~clk;

  nb_dot_ctrl_if bus();

  nb_dot_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic signed [15:0] x_mem [256];
  logic signed [15:0] w_mem [256];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.x_data <= x_mem[bus.x_addr];
      bus.w_data <= w_mem[bus.w_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int edges;
  int rd_cnt;
  logic [7:0] xa_log [$];
  localparam logic [35:0] EXP_NEG = 36'(-65529);

  function automatic logic [35:0] golden(input int n, input logic [7:0] xb, input logic [7:0] wb);
    logic signed [35:0] s;
    logic signed [31:0] p;
    s = '0;
    for (int i = 0; i < n; i++) begin
      p = x_mem[8'(xb + i)] * w_mem[8'(wb + i)];
      s = s + {{4{p[31]}}, p};
    end
    return s;
  endfunction

  task automatic launch(input logic [8:0] n, input logic [7:0] xb, input logic [7:0] wb);
    @(negedge clk);
    bus.start = 1'b1; bus.len = n; bus.x_base = xb; bus.w_base = wb;
    @(negedge clk);
    bus.start = 1'b0; bus.len = 9'd7; bus.x_base = 8'hAA; bus.w_base = 8'h55;
  endtask

  // Called at the falling edge after the accept edge; counts edges until res_valid.
  task automatic wait_result;
    edges = 0; rd_cnt = 0; xa_log.delete();
    while (!bus.res_valid && edges < 600) begin
      if (bus.rd_en) begin rd_cnt++; xa_log.push_back(bus.x_addr); end
      @(posedge clk); edges++;
      @(negedge clk);
    end
  endtask

  task automatic handshake;
    @(negedge clk); bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.busy, bus.rd_en, bus.res_valid, bus.ovf} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.rd_en, bus.res_valid, bus.ovf}); end
    checks++; if ({bus.x_addr, bus.w_addr} !== 16'h0000) begin errors++;
      $display("FAIL reset_addr: got %h expected 0000", {bus.x_addr, bus.w_addr}); end
    checks++; if (bus.result !== 36'd0) begin errors++;
      $display("FAIL reset_result: got %0d expected 0", bus.result); end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_job;
    launch(9'd4, 8'd0, 8'd0);
    @(posedge clk); @(posedge clk); #2;
    checks++; if (bus.rd_en !== 1'b1 || bus.result !== 36'd240) begin errors++;
      $display("FAIL midjob_pre: got rd_en=%b result=%0d expected 1 240", bus.rd_en, bus.result); end
    reset_n = 1'b0; #1;
    checks++; if ({bus.busy, bus.rd_en, bus.res_valid, bus.ovf, bus.x_addr, bus.w_addr} !== 20'h0) begin errors++;
      $display("FAIL midjob_reset: got %h expected 0", {bus.busy, bus.rd_en, bus.res_valid, bus.ovf, bus.x_addr, bus.w_addr}); end
    checks++; if (bus.result !== 36'd0) begin errors++;
      $display("FAIL midjob_result: got %0d expected 0", bus.result); end
    @(negedge clk); reset_n = 1'b1;
    launch(9'd1, 8'd20, 8'd20);
    wait_result();
    checks++; if (bus.result !== 36'd15 || edges != 2) begin errors++;
      $display("FAIL after_reset_job: got result=%0d edges=%0d expected 15 2", bus.result, edges); end
    handshake();
  endtask

  task automatic test_basic;
    launch(9'd3, 8'd0, 8'd0);
    wait_result();
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL basic_rd_cycles: got %0d expected 3", rd_cnt); end
    checks++; if (edges != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", edges); end
    checks++; if (bus.result !== 36'd760 || bus.ovf !== 1'b0) begin errors++;
      $display("FAIL basic_result: got %0d ovf=%b expected 760 0", bus.result, bus.ovf); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    handshake();
    checks++; if ({bus.busy, bus.res_valid} !== 2'b00) begin errors++;
      $display("FAIL basic_release: got %b expected 00", {bus.busy, bus.res_valid}); end
  endtask

  task automatic test_signed_len0;
    launch(9'd2, 8'd10, 8'd10);
    wait_result();
    checks++; if (bus.result !== EXP_NEG || edges != 3) begin errors++;
      $display("FAIL signed_result: got %h edges=%0d expected %h 3", bus.result, edges, EXP_NEG); end
    handshake();
    launch(9'd0, 8'd10, 8'd10);
    wait_result();
    checks++; if (edges != 1 || rd_cnt != 0) begin errors++;
      $display("FAIL len0_timing: got edges=%0d reads=%0d expected 1 0", edges, rd_cnt); end
    checks++; if (bus.result !== 36'd0 || bus.res_valid !== 1'b1) begin errors++;
      $display("FAIL len0_result: got %0d valid=%b expected 0 1", bus.result, bus.res_valid); end
    handshake();
  endtask

  task automatic test_wrap_backpressure;
    logic [31:0] seq;
    launch(9'd4, 8'd254, 8'd30);
    wait_result();
    seq = '0;
    if (xa_log.size() == 4) seq = {xa_log[0], xa_log[1], xa_log[2], xa_log[3]};
    checks++; if (seq !== {8'd254, 8'd255, 8'd0, 8'd1}) begin errors++;
      $display("FAIL wrap_addr: got %h (n=%0d) expected feff0001", seq, xa_log.size()); end
    checks++; if (bus.result !== 36'd35) begin errors++;
      $display("FAIL wrap_result: got %0d expected 35", bus.result); end
    for (int i = 0; i < 10; i++) begin
      bus.start = (i % 2 == 0); bus.len = 9'd2;
      @(negedge clk);
      checks++; if ({bus.busy, bus.res_valid, bus.rd_en} !== 3'b110 || bus.result !== 36'd35) begin errors++;
        $display("FAIL backpressure_hold: cycle %0d got flags=%b result=%0d expected 110 35",
                 i, {bus.busy, bus.res_valid, bus.rd_en}, bus.result); end
    end
    bus.start = 1'b0;
    handshake();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL backpressure_no_queue: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    logic [35:0] exp;
    launch(9'd3, 8'd0, 8'd0);
    wait_result();
    exp = golden(3, 8'd0, 8'd0);
    checks++; if (bus.result !== exp) begin errors++;
      $display("FAIL b2b_first: got %0d expected %0d", bus.result, exp); end
    @(negedge clk);
    bus.res_ready = 1'b1; bus.start = 1'b1; bus.len = 9'd1; bus.x_base = 8'd20; bus.w_base = 8'd20;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL b2b_handshake_start: got busy=%b expected 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++;
      $display("FAIL b2b_next_accept: got busy=%b expected 1", bus.busy); end
    wait_result();
    exp = golden(1, 8'd20, 8'd20);
    checks++; if (bus.result !== exp || edges != 2) begin errors++;
      $display("FAIL b2b_second: got %0d edges=%0d expected %0d 2", bus.result, edges, exp); end
    handshake();
  endtask

  task automatic test_overflow;
    logic [35:0] exp;
    for (int i = 0; i < 256; i++) begin x_mem[i] = -16'sd32768; w_mem[i] = -16'sd32768; end
    launch(9'd256, 8'd0, 8'd0);
    wait_result();
    exp = golden(256, 8'd0, 8'd0);
    checks++; if (edges != 257 || rd_cnt != 256) begin errors++;
      $display("FAIL ovf_timing: got edges=%0d reads=%0d expected 257 256", edges, rd_cnt); end
    checks++; if (bus.result !== exp || bus.result !== 36'd0) begin errors++;
      $display("FAIL ovf_result: got %h expected %h", bus.result, exp); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.ovf); end
    handshake();
    x_mem[5] = 16'sd3; w_mem[7] = 16'sd5;
    launch(9'd1, 8'd5, 8'd7);
    wait_result();
    checks++; if (bus.ovf !== 1'b0 || bus.result !== 36'd15) begin errors++;
      $display("FAIL ovf_clear: got ovf=%b result=%0d expected 0 15", bus.ovf, bus.result); end
    handshake();
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.x_base = '0; bus.w_base = '0; bus.res_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin x_mem[i] = '0; w_mem[i] = '0; end
    x_mem[0] = 16'sd12; x_mem[1] = 16'sd20; x_mem[2] = 16'sd16; x_mem[3] = 16'sd7;
    w_mem[0] = 16'sd20; w_mem[1] = 16'sd10; w_mem[2] = 16'sd20; w_mem[3] = 16'sd2;
    x_mem[10] = -16'sd32768; x_mem[11] = -16'sd1;
    w_mem[10] = 16'sd2;      w_mem[11] = -16'sd7;
    x_mem[20] = 16'sd3;      w_mem[20] = 16'sd5;
    x_mem[254] = 16'sd1;     x_mem[255] = 16'sd2;
    for (int i = 30; i < 34; i++) w_mem[i] = 16'sd1;

    test_reset();
    test_reset_mid_job();
    test_basic();
    test_signed_len0();
    test_wrap_backpressure();
    test_back_to_back();
    test_overflow();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
